// File: rtl/fu_result_stage_pkg.sv
// Shared definitions for the result stage: flag bit positions, opcode
// classes, FIFO occupancy states and the flag-update rule.
package fu_result_stage_pkg;

  // Bit positions inside the architectural flag register {Z,N,C,V}.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Opcode class lives in opcode[3:2].
  localparam logic [1:0] CLASS_LOGIC = 2'b00;
  localparam logic [1:0] CLASS_ADD   = 2'b01;
  localparam logic [1:0] CLASS_MUL   = 2'b10;
  localparam logic [1:0] CLASS_SHIFT = 2'b11;

  // Occupancy of the two-entry result buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Add/sub results own all four flags; every other class only reports
  // Z and N, so C and V keep whatever the last add/sub left behind.
  function automatic logic [3:0] next_flags(input logic [3:0] cur,
                                            input logic [3:0] opcode,
                                            input logic [3:0] status);
    logic [3:0] nf;
    nf = cur;
    nf[FLAG_Z] = status[FLAG_Z];
    nf[FLAG_N] = status[FLAG_N];
    case (opcode[3:2])
      CLASS_ADD: begin
        nf[FLAG_C] = status[FLAG_C];
        nf[FLAG_V] = status[FLAG_V];
      end
      CLASS_LOGIC, CLASS_MUL, CLASS_SHIFT: ;
      default: ;
    endcase
    return nf;
  endfunction

endpackage

// File: rtl/fu_result_stage_fifo.sv
// Two-entry in-order buffer built as a head register plus a skid register.
// The head register drives the output directly, so the output is registered
// and simply holds its last value once the buffer drains or is flushed.
module sync_fifo2
  import fu_result_stage_pkg::*;
#(
  parameter int DW = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o
);

  occ_e          occ_q, occ_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;

  // Occupancy state register.
  // NOTE: sequential state is always updated with <= so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= OCC_EMPTY;
    else        occ_q <= occ_d;
  end

  // Next occupancy and data movement; flush wins over push and pop.
  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push_i) begin
            occ_d  = OCC_ONE;
            head_d = push_data_i;
          end
        end
        OCC_ONE: begin
          if (push_i && pop_i) begin
            head_d = push_data_i;
          end else if (push_i) begin
            occ_d  = OCC_FULL;
            tail_d = push_data_i;
          end else if (pop_i) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop_i) begin
            head_d = tail_q;
            if (push_i) tail_d = push_data_i;
            else        occ_d  = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the storage is reset because the head register is the visible
  // output and must read zero out of reset; a deeper RAM would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign head_o  = head_q;
  assign full_o  = (occ_q == OCC_FULL);
  assign empty_o = (occ_q == OCC_EMPTY);

endmodule

// File: rtl/fu_result_stage.sv
// Result stage behind the functional unit: buffers results toward the
// register-file write port, keeps the architectural flags and counts every
// accepted result.
module fu_result_stage
  import fu_result_stage_pkg::*;
#(
  parameter int width   = 16,
  parameter int regaddr = 3,
  parameter int cntw    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [width-1:0]   in_y,
  input  logic [3:0]         in_status,
  input  logic [3:0]         in_opcode,
  input  logic [regaddr-1:0] in_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [width-1:0]   out_data,
  output logic [regaddr-1:0] out_rd,
  output logic [3:0]         flags,
  output logic [cntw-1:0]    retired
);

  localparam int EW = regaddr + width;

  logic            ready_en_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic [EW-1:0]   fifo_head;
  logic            accept;
  logic            push;
  logic            emit;
  logic [3:0]      flags_q, flags_d;
  logic [cntw-1:0] retired_q, retired_d;

  // Holds in_ready low while in reset and opens it from the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  assign in_ready  = ready_en_q && !fifo_full && !flush;
  assign accept    = in_valid && in_ready;
  // Writes to r0 are architecturally void, so they never reach the port.
  assign push      = accept && (in_rd != '0);
  assign out_valid = !fifo_empty;
  assign emit      = out_valid && out_ready;

  sync_fifo2 #(
    .DW (EW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i ({in_rd, in_y}),
    .pop_i       (emit),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign {out_rd, out_data} = fifo_head;

  // Flags and retire count move only on an accepted result.
  always_comb begin
    flags_d   = flags_q;
    retired_d = retired_q;
    if (accept) begin
      flags_d   = next_flags(flags_q, in_opcode, in_status);
      retired_d = retired_q + 1'b1;
    end
  end

  // Flag register and retired-result counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= '0;
      retired_q <= '0;
    end else begin
      flags_q   <= flags_d;
      retired_q <= retired_d;
    end
  end

  assign flags   = flags_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_fu_result_stage.sv
// Scoreboard bench for fu_result_stage: stimulus pushes expected write-port
// entries, an independent monitor pops and compares them on each emit.
module tb_fu_result_stage;

  localparam int W  = 16;
  localparam int RA = 3;
  localparam int CW = 16;

  typedef struct packed {
    logic [RA-1:0] rd;
    logic [W-1:0]  data;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_y = '0;
  logic [3:0]    in_status = '0;
  logic [3:0]    in_opcode = '0;
  logic [RA-1:0] in_rd = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [RA-1:0] out_rd;
  logic [3:0]    flags;
  logic [CW-1:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  entry_t        exp_q[$];
  int            m_occ;
  logic [3:0]    m_flags;
  logic [CW-1:0] m_retired;
  entry_t        last_out;
  bit            have_last;
  entry_t        mon_e;

  fu_result_stage #(
    .width   (W),
    .regaddr (RA),
    .cntw    (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_status (in_status),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .flags     (flags),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural flag rule: add/sub writes all flags, others only Z,N.
  function automatic logic [3:0] ref_flags(input logic [3:0] f, input logic [3:0] op,
                                           input logic [3:0] st);
    if (op[3:2] == 2'b01) return st;
    return {st[3:2], f[1:0]};
  endfunction

  // Monitor: every emit must match the oldest outstanding expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_emit: got rd=%0h data=%0h expected no entry", out_rd, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(mon_e.data));
          check("out_rd", 32'(out_rd), 32'(mon_e.rd));
          last_out  = mon_e;
          have_last = 1'b1;
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic model_clear();
    exp_q.delete();
    m_occ     = 0;
    m_flags   = '0;
    m_retired = '0;
    last_out  = '0;
    have_last = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_rd"}, 32'(out_rd), 32'd0);
    check({tag, "_flags"}, 32'(flags), 32'd0);
    check({tag, "_retired"}, 32'(retired), 32'd0);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_y = '0; in_rd = '0; in_opcode = '0; in_status = '0;
    flush = 1'b0; out_ready = 1'b0;
  endtask

  // Hold reset for a couple of edges, release, and end at posedge+1.
  task automatic finish_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  // One cycle of stimulus; called at posedge+1, returns at posedge+1.
  task automatic step(input bit v, input logic [W-1:0] y, input logic [RA-1:0] rd,
                      input logic [3:0] op, input logic [3:0] st, input bit fl, input bit ordy);
    bit     exp_rdy;
    bit     acc;
    bit     emit;
    entry_t ne;
    in_valid = v; in_y = y; in_rd = rd; in_opcode = op; in_status = st;
    flush = fl; out_ready = ordy;
    @(negedge clk);
    exp_rdy = (m_occ < 2) && !fl;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_occ > 0));
    if (m_occ == 0 && have_last) begin
      check("hold_data", 32'(out_data), 32'(last_out.data));
      check("hold_rd", 32'(out_rd), 32'(last_out.rd));
    end
    acc  = v && exp_rdy;
    emit = (m_occ > 0) && ordy;
    if (acc) begin
      m_retired = m_retired + 1'b1;
      m_flags   = ref_flags(m_flags, op, st);
      if (rd != 0) begin
        ne.rd = rd;
        ne.data = y;
        exp_q.push_back(ne);
      end
    end
    m_occ = m_occ + ((acc && rd != 0) ? 1 : 0) - (emit ? 1 : 0);
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      m_occ = 0;
      have_last = 1'b0;
    end
    check("flags", 32'(flags), 32'(m_flags));
    check("retired", 32'(retired), 32'(m_retired));
  endtask

  initial begin
    idle_inputs();
    #1;
    rst_n = 1'b0;
    finish_reset();

    // Single add result, drained immediately.
    step(1, 16'h1234, 3'd3, 4'b0100, 4'b0010, 0, 1);
    step(0, '0, '0, '0, '0, 0, 1);
    step(0, '0, '0, '0, '0, 0, 1);

    // Backpressure: fill, hold off a third, then drain in order.
    step(1, 16'hAAAA, 3'd1, 4'b0100, 4'b0000, 0, 0);
    step(1, 16'h5555, 3'd2, 4'b0100, 4'b0000, 0, 0);
    step(1, 16'h7777, 3'd4, 4'b0100, 4'b0000, 0, 0);
    step(1, 16'h7777, 3'd4, 4'b0100, 4'b0000, 0, 1);
    step(1, 16'h7777, 3'd4, 4'b0100, 4'b0000, 0, 1);
    step(0, '0, '0, '0, '0, 0, 1);
    step(0, '0, '0, '0, '0, 0, 1);

    // Flag classes: add sets all four, logic keeps C,V; then rd=0 discard.
    step(1, 16'h0001, 3'd5, 4'b0100, 4'b0011, 0, 1);
    step(1, 16'h0002, 3'd6, 4'b0000, 4'b1000, 0, 1);
    step(1, 16'hFFFF, 3'd0, 4'b1000, 4'b0100, 0, 1);
    step(0, '0, '0, '0, '0, 0, 1);
    step(0, '0, '0, '0, '0, 0, 1);

    // Flush while full with a valid offer.
    step(1, 16'h1111, 3'd1, 4'b1100, 4'b1111, 0, 0);
    step(1, 16'h2222, 3'd2, 4'b0100, 4'b0101, 0, 0);
    step(1, 16'h3333, 3'd3, 4'b0100, 4'b1010, 1, 0);
    step(0, '0, '0, '0, '0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), W'($urandom), RA'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-stream with out_valid high.
    step(1, 16'hBEEF, 3'd7, 4'b0100, 4'b1111, 0, 0);
    step(1, 16'hCAFE, 3'd6, 4'b0100, 4'b1111, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    idle_inputs();
    finish_reset();

    // Counter wrap: 65535 discarded accepts, then one more.
    in_valid = 1'b1; in_y = 16'h0F0F; in_rd = '0; in_opcode = 4'b0100; in_status = 4'b0000;
    flush = 1'b0; out_ready = 1'b0;
    m_flags = ref_flags(m_flags, 4'b0100, 4'b0000);
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
      m_retired = m_retired + 1'b1;
    end
    #1;
    check("retired_max", 32'(retired), 32'h0000FFFF);
    step(1, 16'h0F0F, 3'd0, 4'b0100, 4'b0000, 0, 0);
    check("retired_wrap", 32'(retired), 32'd0);
    step(0, '0, '0, '0, '0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
